// File: rtl/sqrt_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : sqrt_pkg                                                       |
// | Shared types and constants for the square-root result display slice:     |
// | FSM state encoding, display slot / conversion counts and the 7-segment   |
// | code table with its decode helper.                                       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package sqrt_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CONV_ROOT = 2'd1,
      CONV_REM  = 2'd2,
      SHOW      = 2'd3
   } state_t;

   localparam int NUM_SLOTS = 5;
   localparam int BCD_ITERS = 5;

   // Segment codes, bit order {g,f,e,d,c,b,a}, active high.
   localparam logic [6:0] SEG_CODES [10] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

   // Non-decimal nibbles cannot occur for legal operands; blank them anyway.
   function automatic logic [6:0] seg_decode(input logic [3:0] digit);
      if (digit <= 4'd9) begin
         return SEG_CODES[digit];
      end
      return 7'h00;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sqrt_result_display_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : sqrt_result_display_if                                       |
// | Valid/ready result channel from the square-root core.                    |
// |   in_valid : result valid (source -> sink)                               |
// |   in_ready : sink can accept a result (sink -> source)                   |
// |   in_root  : square root 0..15                                           |
// |   in_rem   : remainder 0..31                                             |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface sqrt_result_display_if;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_root;
   logic [4:0] in_rem;

   modport master (
      output in_valid,
      output in_root,
      output in_rem,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_root,
      input  in_rem,
      output in_ready
   );
endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : bin2bcd_seq                                                     |
// | Sequential double-dabble: 5-bit binary to two BCD digits, one            |
// | add-3/shift iteration per clock.                                         |
// |   clk, rst_n : clock, synchronous active-low reset                       |
// |   start_i    : load bin_i; iterations run on the following 5 edges       |
// |   bin_i      : binary operand                                            |
// |   bcd_o      : {tens, units}, valid while done_o is high                 |
// |   done_o     : high in the cycle whose closing edge completes the result |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module bin2bcd_seq
   import sqrt_pkg::*;
(
   input  wire        clk,
   input  wire        rst_n,
   input  wire        start_i,
   input  wire  [4:0] bin_i,
   output logic [7:0] bcd_o,
   output logic       done_o
);

   localparam logic [2:0] ITER_LAST = 3'(BCD_ITERS - 1);

   // {tens[12:9], units[8:5], binary[4:0]}
   logic [12:0] sh_q;
   logic [2:0]  cnt_q;
   logic        active_q;
   logic [12:0] adj;
   logic [12:0] nxt;

   always_comb begin
      adj = sh_q;
      if (sh_q[8:5] >= 4'd5) begin
         adj[8:5] = sh_q[8:5] + 4'd3;
      end
      if (sh_q[12:9] >= 4'd5) begin
         adj[12:9] = sh_q[12:9] + 4'd3;
      end
      nxt = adj << 1;
   end

   // The result is taken straight from the final iteration so the consumer
   // latches it on the same edge the iteration completes.
   assign bcd_o  = nxt[12:5];
   assign done_o = active_q && (cnt_q == ITER_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sh_q     <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else if (start_i) begin
         sh_q     <= {8'd0, bin_i};
         cnt_q    <= '0;
         active_q <= 1'b1;
      end else if (active_q) begin
         sh_q  <= nxt;
         cnt_q <= cnt_q + 3'd1;
         if (cnt_q == ITER_LAST) begin
            active_q <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/sqrt_result_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : sqrt_result_display                                             |
// | Accepts {root, remainder} results, converts them to BCD and cycles the   |
// | 7-segment display through root tens/units, remainder tens/units (with    |
// | decimal point) and a blank separator, each held HOLD_CYCLES clocks.      |
// |   clk, rst_n : clock, synchronous active-low reset                       |
// |   in_if      : result channel (slave side)                               |
// |   seg        : segments {g,f,e,d,c,b,a}, active high                     |
// |   dp         : decimal point, marks remainder digits                     |
// |   digit_sel  : current display slot 0..4                                 |
// |   busy       : conversion in progress                                    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module sqrt_result_display
   import sqrt_pkg::*;
#(
   parameter int HOLD_CYCLES = 1024
) (
   input  wire                        clk,
   input  wire                        rst_n,
   sqrt_result_display_if.slave       in_if,
   output logic [6:0]                 seg,
   output logic                       dp,
   output logic [2:0]                 digit_sel,
   output logic                       busy
);

   localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
   localparam logic [2:0]  SLOT_LAST = 3'(NUM_SLOTS - 1);

   state_t      state_q, state_d;
   logic [4:0]  rem_q, rem_d;
   logic [7:0]  root_bcd_q, root_bcd_d;
   logic [7:0]  rem_bcd_q, rem_bcd_d;
   logic [15:0] hold_q, hold_d;
   logic [2:0]  slot_q, slot_d;
   logic        ready_q, ready_d;
   logic        busy_q, busy_d;
   logic [6:0]  seg_q, seg_d;
   logic        dp_q, dp_d;
   logic [2:0]  sel_q, sel_d;

   logic        xfer;
   logic        bcd_start;
   logic [4:0]  bcd_bin;
   logic [7:0]  bcd_res;
   logic        bcd_done;

   bin2bcd_seq u_bin2bcd (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (bcd_start),
      .bin_i   (bcd_bin),
      .bcd_o   (bcd_res),
      .done_o  (bcd_done)
   );

   assign xfer = in_if.in_valid && ready_q;

   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      root_bcd_d = root_bcd_q;
      rem_bcd_d  = rem_bcd_q;
      hold_d     = hold_q;
      slot_d     = slot_q;
      bcd_start  = 1'b0;
      bcd_bin    = rem_q;

      case (state_q)
         IDLE, SHOW: begin
            if (xfer) begin
               // The root goes straight into the converter; only the
               // remainder needs holding until the second pass.
               state_d   = CONV_ROOT;
               rem_d     = in_if.in_rem;
               bcd_start = 1'b1;
               bcd_bin   = {1'b0, in_if.in_root};
            end else if (state_q == SHOW) begin
               if (hold_q == HOLD_LAST) begin
                  hold_d = '0;
                  slot_d = (slot_q == SLOT_LAST) ? 3'd0 : slot_q + 3'd1;
               end else begin
                  hold_d = hold_q + 16'd1;
               end
            end
         end
         CONV_ROOT: begin
            if (bcd_done) begin
               root_bcd_d = bcd_res;
               state_d    = CONV_REM;
               bcd_start  = 1'b1;
            end
         end
         CONV_REM: begin
            if (bcd_done) begin
               rem_bcd_d = bcd_res;
               state_d   = SHOW;
               hold_d    = '0;
               slot_d    = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from next-state values so every display output
      // is a plain register and the first slot appears on the SHOW entry edge.
      ready_d = (state_d == IDLE) || (state_d == SHOW);
      busy_d  = !ready_d;
      seg_d   = 7'h00;
      dp_d    = 1'b0;
      sel_d   = 3'd0;
      if (state_d == SHOW) begin
         sel_d = slot_d;
         case (slot_d)
            3'd0: seg_d = seg_decode(root_bcd_d[7:4]);
            3'd1: seg_d = seg_decode(root_bcd_d[3:0]);
            3'd2: begin
               seg_d = seg_decode(rem_bcd_d[7:4]);
               dp_d  = 1'b1;
            end
            3'd3: begin
               seg_d = seg_decode(rem_bcd_d[3:0]);
               dp_d  = 1'b1;
            end
            default: seg_d = 7'h00;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rem_q      <= '0;
         root_bcd_q <= '0;
         rem_bcd_q  <= '0;
         hold_q     <= '0;
         slot_q     <= '0;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
         seg_q      <= '0;
         dp_q       <= 1'b0;
         sel_q      <= '0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         root_bcd_q <= root_bcd_d;
         rem_bcd_q  <= rem_bcd_d;
         hold_q     <= hold_d;
         slot_q     <= slot_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         sel_q      <= sel_d;
      end
   end

   assign in_if.in_ready = ready_q;
   assign busy           = busy_q;
   assign seg            = seg_q;
   assign dp             = dp_q;
   assign digit_sel      = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_sqrt_result_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_sqrt_result_display                                          |
// | Directed self-checking bench for sqrt_result_display, HOLD_CYCLES = 4.   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_sqrt_result_display;

   localparam int HOLD = 4;

   logic       clk;
   logic       rst_n;
   logic [6:0] seg;
   logic       dp;
   logic [2:0] digit_sel;
   logic       busy;

   int checks = 0;
   int errors = 0;

   sqrt_result_display_if u_if ();

   sqrt_result_display #(.HOLD_CYCLES(HOLD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_if     (u_if),
      .seg       (seg),
      .dp        (dp),
      .digit_sel (digit_sel),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_seg"},   16'(seg), 16'h00);
      chk({tag, "_dp"},    16'(dp), 16'd0);
      chk({tag, "_sel"},   16'(digit_sel), 16'd0);
      chk({tag, "_ready"}, 16'(u_if.in_ready), 16'd1);
      chk({tag, "_busy"},  16'(busy), 16'd0);
   endtask

   task automatic xfer(input logic [3:0] root, input logic [4:0] rem);
      u_if.in_valid = 1'b1;
      u_if.in_root  = root;
      u_if.in_rem   = rem;
      tick();
      u_if.in_valid = 1'b0;
   endtask

   // Samples after edges E0..E0+9; returns at the sample after E0+10.
   task automatic wait_conv();
      for (int i = 0; i < 10; i++) begin
         chk("conv_ready", 16'(u_if.in_ready), 16'd0);
         chk("conv_busy",  16'(busy), 16'd1);
         chk("conv_seg",   16'(seg), 16'h00);
         chk("conv_sel",   16'(digit_sel), 16'd0);
         tick();
      end
   endtask

   // Starts at hold 0 of slot 0 and checks ncyc consecutive cycles.
   task automatic show(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3, input int ncyc);
      int k;
      logic [6:0] es;
      for (int n = 0; n < ncyc; n++) begin
         k = (n / HOLD) % 5;
         case (k)
            0: es = s0;
            1: es = s1;
            2: es = s2;
            3: es = s3;
            default: es = 7'h00;
         endcase
         chk("show_seg",   16'(seg), 16'(es));
         chk("show_dp",    16'(dp), (k == 2 || k == 3) ? 16'd1 : 16'd0);
         chk("show_sel",   16'(digit_sel), 16'(k));
         chk("show_ready", 16'(u_if.in_ready), 16'd1);
         chk("show_busy",  16'(busy), 16'd0);
         tick();
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      u_if.in_valid = 1'b0;
      u_if.in_root  = '0;
      u_if.in_rem   = '0;
      tick();
      tick();
      rst_n = 1'b1;

      // Reset state and 20 idle cycles.
      for (int i = 0; i < 20; i++) begin
         chk_idle("idle");
         tick();
      end

      // 85: root 9, rem 4.
      xfer(4'd9, 5'd4);
      wait_conv();
      show(7'h3F, 7'h6F, 7'h3F, 7'h66, 40);

      // 255: root 15, rem 30.
      xfer(4'd15, 5'd30);
      wait_conv();
      show(7'h06, 7'h6D, 7'h4F, 7'h3F, 20);

      // root 0 rem 0, then in_valid held with root 3 rem 1 during conversion.
      u_if.in_valid = 1'b1;
      u_if.in_root  = 4'd0;
      u_if.in_rem   = 5'd0;
      tick();
      u_if.in_root  = 4'd3;
      u_if.in_rem   = 5'd1;
      wait_conv();
      chk("zero_ready", 16'(u_if.in_ready), 16'd1);
      chk("zero_seg",   16'(seg), 16'h3F);
      chk("zero_dp",    16'(dp), 16'd0);
      chk("zero_sel",   16'(digit_sel), 16'd0);
      tick();
      u_if.in_valid = 1'b0;
      wait_conv();
      show(7'h3F, 7'h4F, 7'h3F, 7'h06, 20);

      // Abandon display in slot 2: root 7, rem 13.
      for (int i = 0; i < 2 * HOLD; i++) tick();
      chk("slot2_sel", 16'(digit_sel), 16'd2);
      chk("slot2_dp",  16'(dp), 16'd1);
      chk("slot2_seg", 16'(seg), 16'h3F);
      tick();
      xfer(4'd7, 5'd13);
      chk("abort_busy",  16'(busy), 16'd1);
      chk("abort_ready", 16'(u_if.in_ready), 16'd0);
      wait_conv();
      show(7'h3F, 7'h07, 7'h06, 7'h4F, 20);

      // Reset at E0+6 with a simultaneous valid: reset must win.
      xfer(4'd9, 5'd4);
      for (int i = 0; i < 5; i++) tick();
      rst_n         = 1'b0;
      u_if.in_valid = 1'b1;
      u_if.in_root  = 4'd5;
      u_if.in_rem   = 5'd5;
      tick();
      rst_n         = 1'b1;
      u_if.in_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk_idle("rst");
         tick();
      end

      // 164: root 12, rem 20 after the reset.
      xfer(4'd12, 5'd20);
      wait_conv();
      show(7'h06, 7'h5B, 7'h5B, 7'h3F, 20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sqrt_result_display.md
# sqrt_result_display

Downstream stage of the 8-bit digit-by-digit square-root core. Accepts one {root, remainder} result per valid/ready handshake and converts both fields to two-digit BCD with a sequential double-dabble. It then drives the single 7-segment display on uo_out, cycling through root tens, root units, remainder tens, remainder units and a blank separator. The cycle repeats until a new result is accepted.

## Interface
Parameters:
- HOLD_CYCLES, default 1024: clock cycles each display slot is held; legal range 1..65535.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset: rst_n, synchronous, active-low; clock clk
- in_valid  input  1  result from sqrt core is valid
- in_ready  output  1  block can accept a result this cycle
- in_root  input  4  square root, 0..15
- in_rem  input  5  remainder, 0..31
- seg  output  7  segments {g,f,e,d,c,b,a}, active high
- dp  output  1  decimal point; marks remainder digits
- digit_sel  output  3  current display slot 0..4
- busy  output  1  high while converting

## Operation
- States: IDLE, CONV_ROOT, CONV_REM, SHOW.
- Handshake: transfer occurs on a rising edge with in_valid && in_ready. in_root and in_rem are captured only on transfer. in_valid outside a transfer is ignored; no queueing.
- in_ready = 1 in IDLE and SHOW; 0 in CONV_ROOT and CONV_REM. busy = !in_ready once out of reset.
- IDLE: seg=0, dp=0, digit_sel=0. Transfer -> CONV_ROOT.
- CONV_ROOT: in_root is zero-extended to 5 bits and given 5 double-dabble iterations, one per cycle. Each iteration adds 3 to any BCD nibble >= 5, then shifts left 1. Result is latched as root_bcd[7:0]. Then -> CONV_REM.
- CONV_REM: same 5-iteration conversion on in_rem, latched as rem_bcd[7:0]. Then -> SHOW with slot=0 and hold counter=0.
- SHOW: hold counter counts 0..HOLD_CYCLES-1. At the terminal count it wraps to 0 and slot advances; slot 4 wraps to 0.
- Slot contents:
  - slot 0: root tens
  - slot 1: root units
  - slot 2: rem tens, dp=1
  - slot 3: rem units, dp=1
  - slot 4: seg=0, dp=0
- Leading zeros are displayed as '0', not blanked.
- Transfer in SHOW, in any slot at any hold count, goes -> CONV_ROOT with the new operands. The old display is abandoned.
- During CONV_*: seg=0, dp=0, digit_sel=0.
- Segment codes (hex, gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F. BCD nibbles are always <= 9 for legal inputs.

## Timing
- Reset values (rst_n low at a rising edge): state=IDLE, in_ready=1, busy=0, seg=0, dp=0, digit_sel=0, hold counter=0, slot=0, BCD registers=0.
- Reset has priority over a simultaneous transfer.
- Transfer at edge E0. Root iterations occur at edges E0+1..E0+5. Rem iterations occur at edges E0+6..E0+10.
- SHOW is entered at E0+10. Slot 0 is visible on seg from E0+10 for HOLD_CYCLES cycles.
- in_ready is low from E0 to E0+10; the next transfer can occur at edge E0+11 at the earliest.
- Slot k (k=0..4) is displayed from edge E0+10+k*HOLD_CYCLES. The sequence repeats every 5*HOLD_CYCLES cycles.
- HOLD_CYCLES=1: slot advances every cycle.
- All outputs are registered; seg/dp/digit_sel are glitch-free and change only on clk edges.
- Reset mid-conversion or mid-SHOW: the next cycle is IDLE with all reset values. Partial BCD is discarded.

## Structure
- Shared package sqrt_pkg holds:
  - state enum (IDLE/CONV_ROOT/CONV_REM/SHOW)
  - 10-entry 7-bit segment code constant array
  - NUM_SLOTS=5, BCD_ITERS=5
- Sub-module bin2bcd_seq: 5-bit binary in, 8-bit BCD out, with start/done and 5-cycle latency.
  - Instantiated once and reused for root then remainder.
  - start pulses at E0 and at E0+5; done is asserted in the cycle its result latches.
- Top level contains the FSM, hold counter, slot counter and segment decode.

## Test plan
- Reset, then idle for 20 cycles -> seg=00, dp=0, digit_sel=0, in_ready=1, busy=0 throughout.
- HOLD_CYCLES=4; transfer root=9, rem=4 (input 85) -> in_ready=0 for 10 cycles, then seg sequence 3F, 6F, 3F(dp=1), 66(dp=1), 00, each held 4 cycles, repeating.
- Transfer root=15, rem=30 (input 255) -> digits 1, 5, 3, 0 = seg 06, 6D, 4F, 3F, with dp=1 on slots 2-3.
- Transfer root=0, rem=0, then hold in_valid=1 with root=3, rem=1 throughout conversion -> second result is not taken until E0+11; first display shows 3F,3F,3F,3F.
- During SHOW slot 2, transfer root=7, rem=13 -> busy next cycle; 10 cycles later slot 0 shows seg 3F, then 07, 06(dp), 4F(dp).
- rst_n low for 1 cycle at E0+6 -> IDLE next cycle, seg=00, in_ready=1; a later transfer converts correctly.
